// File: rtl/ioboard_pkg.sv
// Shared constants for the I/O board switch front end.
package ioboard_pkg;

  // 2.5 ms sample period at 100 MHz.
  localparam int unsigned DswTickDivDefault   = 250000;
  localparam int unsigned DswFilterLenDefault = 4;

  localparam int unsigned DswBankWidth = 8;
  localparam int unsigned DswNumBanks  = 3;
  // Three banks packed as {bank2, bank1, bank0}.
  localparam int unsigned DswPackWidth = DswBankWidth * DswNumBanks;

  function automatic logic [DswPackWidth-1:0] dsw_pack(input logic [DswBankWidth-1:0] b2,
                                                       input logic [DswBankWidth-1:0] b1,
                                                       input logic [DswBankWidth-1:0] b0);
    return {b2, b1, b0};
  endfunction

endpackage

// File: rtl/dsw_filter_bit.sv
// One switch: 2-flop synchronizer, tick-sampled history, debounced level and change strobe.
module dsw_filter_bit
  import ioboard_pkg::*;
#(
  parameter int unsigned FILTER_LEN = DswFilterLenDefault
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic tick_i,
  output logic stable_o,
  output logic changed_o
);

  logic [1:0]            sync_q, sync_d;
  logic [FILTER_LEN-1:0] hist_q, hist_d;
  logic                  stable_q, stable_d;
  logic                  changed_q, changed_d;

  // Next state: shift history on tick, accept a level once the whole history agrees.
  always_comb begin
    sync_d    = {sync_q[0], raw_i};
    hist_d    = hist_q;
    stable_d  = stable_q;
    changed_d = 1'b0;
    if (tick_i) begin
      hist_d = {hist_q[FILTER_LEN-2:0], sync_q[1]};
      if (&hist_d) begin
        stable_d = 1'b1;
      end else if (~|hist_d) begin
        stable_d = 1'b0;
      end
      changed_d = stable_d ^ stable_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q    <= '0;
      hist_q    <= '0;
      stable_q  <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      stable_q  <= stable_d;
      changed_q <= changed_d;
    end
  end

  assign stable_o  = stable_q;
  assign changed_o = changed_q;

endmodule

// File: rtl/dsw_debounce.sv
// DIP switch debouncer: shared sample prescaler, 24 per-bit filters, valid/ready change events.
module dsw_debounce
  import ioboard_pkg::*;
#(
  parameter int unsigned TICK_DIV   = DswTickDivDefault,
  parameter int unsigned FILTER_LEN = DswFilterLenDefault
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DswBankWidth-1:0] dsw0,
  input  logic [DswBankWidth-1:0] dsw1,
  input  logic [DswBankWidth-1:0] dsw2,
  output logic [DswBankWidth-1:0] stable0,
  output logic [DswBankWidth-1:0] stable1,
  output logic [DswBankWidth-1:0] stable2,
  output logic [DswPackWidth-1:0] changed,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [DswPackWidth-1:0] evt_data,
  output logic                    evt_coalesced
);

  localparam int unsigned CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] TickMax = CntW'(TICK_DIV - 1);
  localparam int NumBits = int'(DswPackWidth);

  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    tick;
  logic [DswPackWidth-1:0] raw_all, stable_all, changed_all;
  logic                    evt_valid_q, evt_valid_d;
  logic [DswPackWidth-1:0] evt_data_q, evt_data_d;
  logic                    evt_coal_q, evt_coal_d;
  logic                    xfer;

  assign raw_all = dsw_pack(dsw2, dsw1, dsw0);

  // Prescaler: count 0..TICK_DIV-1, tick on the terminal count and wrap in the same cycle.
  always_comb begin
    tick  = (cnt_q == TickMax);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  for (genvar i = 0; i < NumBits; i++) begin : g_bit
    dsw_filter_bit #(
      .FILTER_LEN(FILTER_LEN)
    ) u_bit (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .raw_i    (raw_all[i]),
      .tick_i   (tick),
      .stable_o (stable_all[i]),
      .changed_o(changed_all[i])
    );
  end

  // Event next state: a change opens a new event unless one is stuck pending, in which case
  // the newest snapshot overwrites it and the coalesced flag records the merge.
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_data_d  = evt_data_q;
    evt_coal_d  = evt_coal_q;
    xfer        = evt_valid_q & evt_ready;
    if (|changed_all) begin
      evt_data_d = stable_all;
      if (!evt_valid_q || xfer) begin
        evt_valid_d = 1'b1;
        evt_coal_d  = 1'b0;
      end else begin
        evt_coal_d  = 1'b1;
      end
    end else if (xfer) begin
      evt_valid_d = 1'b0;
    end
  end

  // Prescaler and event registers; reset restarts the prescaler and drops any pending event.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_data_q  <= '0;
      evt_coal_q  <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      evt_coal_q  <= evt_coal_d;
    end
  end

  assign stable0       = stable_all[7:0];
  assign stable1       = stable_all[15:8];
  assign stable2       = stable_all[23:16];
  assign changed       = changed_all;
  assign evt_valid     = evt_valid_q;
  assign evt_data      = evt_data_q;
  assign evt_coalesced = evt_coal_q;

endmodule

// File: tb/tb_dsw_debounce.sv
// Self-checking bench for dsw_debounce with a small tick period.
module tb_dsw_debounce;

  localparam int TD = 4;
  localparam int FL = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  dsw0, dsw1, dsw2;
  logic [7:0]  stable0, stable1, stable2;
  logic [23:0] changed;
  logic        evt_valid;
  logic        evt_ready;
  logic [23:0] evt_data;
  logic        evt_coalesced;

  dsw_debounce #(
    .TICK_DIV  (TD),
    .FILTER_LEN(FL)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dsw0         (dsw0),
    .dsw1         (dsw1),
    .dsw2         (dsw2),
    .stable0      (stable0),
    .stable1      (stable1),
    .stable2      (stable2),
    .changed      (changed),
    .evt_valid    (evt_valid),
    .evt_ready    (evt_ready),
    .evt_data     (evt_data),
    .evt_coalesced(evt_coalesced)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: raw words delayed two clocks, a list of the last FL tick samples,
  // and event bookkeeping derived from the handshake rules.
  logic [23:0] syncq[$];
  logic [23:0] smp[$];
  logic [23:0] m_stable = '0;
  logic [23:0] m_chg    = '0;
  logic [23:0] m_data   = '0;
  logic        m_valid  = 1'b0;
  logic        m_coal   = 1'b0;
  int          m_cyc    = 0;

  task automatic model_reset();
    syncq = {24'h0, 24'h0};
    smp   = {};
    for (int i = 0; i < FL; i++) smp.push_back(24'h0);
    m_stable = '0;
    m_chg    = '0;
    m_data   = '0;
    m_valid  = 1'b0;
    m_coal   = 1'b0;
    m_cyc    = 0;
  endtask

  task automatic model_step(input logic [23:0] raw, input logic ready, input logic rstn);
    logic        xfer;
    logic [23:0] s, all1, any1, nst, chg_n;
    if (!rstn) begin
      model_reset();
      return;
    end
    xfer = m_valid && ready;
    if (m_chg != 0) begin
      m_data = m_stable;
      if (!m_valid || xfer) begin
        m_valid = 1'b1;
        m_coal  = 1'b0;
      end else begin
        m_coal  = 1'b1;
      end
    end else if (xfer) begin
      m_valid = 1'b0;
    end
    s = syncq.pop_front();
    syncq.push_back(raw);
    chg_n = '0;
    if (m_cyc % TD == TD - 1) begin
      smp.push_back(s);
      void'(smp.pop_front());
      all1 = '1;
      any1 = '0;
      foreach (smp[i]) begin
        all1 &= smp[i];
        any1 |= smp[i];
      end
      nst      = (m_stable | all1) & any1;
      chg_n    = nst ^ m_stable;
      m_stable = nst;
    end
    m_chg = chg_n;
    m_cyc++;
  endtask

  function automatic logic [127:0] dut_vec();
    return {54'h0, stable2, stable1, stable0, changed, evt_valid, evt_data, evt_coalesced};
  endfunction

  function automatic logic [127:0] exp_vec();
    return {54'h0, m_stable, m_chg, m_valid, m_data, m_coal};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model with the inputs the DUT samples, then compare after the edge.
  task automatic cycle();
    model_step({dsw2, dsw1, dsw0}, evt_ready, rst_n);
    @(posedge clk);
    #1;
    check("model", dut_vec(), exp_vec());
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [23:0] exp_stable;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int nchg, chg_at, ev_at, rises, k;
    logic [23:0] chg_val;
    logic        prev_v;
    logic [23:0] raw, gmask;
    int          glitch_left;

    tbl[0] = '{8'h5A, 8'hC3, 8'h0F, 24'h0FC35A};
    tbl[1] = '{8'hFF, 8'h00, 8'hFF, 24'hFF00FF};
    tbl[2] = '{8'h00, 8'h00, 8'h00, 24'h000000};
    tbl[3] = '{8'h81, 8'h42, 8'h24, 24'h244281};
    tbl[4] = '{8'hA5, 8'h5A, 8'h3C, 24'h3C5AA5};

    rst_n = 1'b0; evt_ready = 1'b0;
    dsw0 = 8'h00; dsw1 = 8'h00; dsw2 = 8'h00;
    cycle();
    check("reset_state", dut_vec(), 128'h0);

    // Switch high from reset release becomes one event.
    dsw0 = 8'h01;
    do_reset();
    nchg = 0; chg_at = 0; ev_at = 0; chg_val = '0;
    for (int i = 1; i <= 20; i++) begin
      cycle();
      if (changed != 0) begin nchg++; chg_val = changed; chg_at = i; end
      if (evt_valid && ev_at == 0) ev_at = i;
    end
    check("029_pulse_count", nchg, 1);
    check("029_changed", chg_val, 24'h000001);
    check("029_evt_in_time", (ev_at > 0 && ev_at <= 20), 1);
    check("029_evt_data", evt_data, 24'h000001);
    check("029_stable0", stable0, 8'h01);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    check("029_accept", evt_valid, 1'b0);

    // Short glitch is rejected.
    dsw1 = 8'h08;
    repeat (8) cycle();
    dsw1 = 8'h00;
    nchg = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (changed != 0) nchg++;
    end
    check("030_stable1", stable1, 8'h00);
    check("030_no_change", nchg, 0);

    // Two changes while the consumer stalls merge into one coalesced event.
    dsw0 = 8'h00;
    do_reset();
    repeat (20) cycle();
    dsw2 = 8'h80;
    repeat (24) cycle();
    check("031_first", {evt_valid, evt_data, evt_coalesced}, {1'b1, 24'h800000, 1'b0});
    dsw0 = 8'h02;
    repeat (24) cycle();
    check("031_merged", {evt_valid, evt_data, evt_coalesced}, {1'b1, 24'h800002, 1'b1});
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    check("031_accept", evt_valid, 1'b0);

    // Transfer coinciding with a new change.
    dsw1 = 8'h10;
    repeat (24) cycle();
    check("032_pending", {evt_valid, evt_data, evt_coalesced}, {1'b1, 24'h801002, 1'b0});
    dsw1 = 8'h30;
    k = 0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (changed != 0) begin k = 1; break; end
    end
    check("032_change_seen", {k[0], changed}, {1'b1, 24'h002000});
    check("032_old_data", evt_data, 24'h801002);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;
    check("032_new_evt", {evt_valid, evt_data, evt_coalesced}, {1'b1, 24'h803002, 1'b0});
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;

    // Reset while an event is pending; the prescaler restarts from zero.
    dsw0 = 8'h03;
    repeat (24) cycle();
    check("033_pending", evt_valid, 1'b1);
    repeat (2) cycle();
    do_reset();
    check("033_all_zero", dut_vec(), 128'h0);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      cycle();
      if (changed != 0) begin k = i; break; end
    end
    check("033_restart_latency", k, 16);
    evt_ready = 1'b1; repeat (3) cycle(); evt_ready = 1'b0;

    // All 24 switches toggle together.
    {dsw2, dsw1, dsw0} = ~24'h803003;
    nchg = 0; rises = 0; chg_val = '0; prev_v = evt_valid;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (changed != 0) begin nchg++; chg_val = changed; end
      if (evt_valid && !prev_v) rises++;
      prev_v = evt_valid;
    end
    check("034_pulse_count", nchg, 1);
    check("034_changed", chg_val, 24'hFFFFFF);
    check("034_events", rises, 1);
    check("034_data", evt_data, 24'h7FCFFC);
    evt_ready = 1'b1; cycle(); evt_ready = 1'b0;

    // Table of settled levels.
    evt_ready = 1'b1;
    for (int t = 0; t < 5; t++) begin
      dsw0 = tbl[t].d0; dsw1 = tbl[t].d1; dsw2 = tbl[t].d2;
      repeat (24) cycle();
      check("tbl_stable", {stable2, stable1, stable0}, tbl[t].exp_stable);
      check("tbl_quiet", {changed, evt_valid}, 25'h0);
    end

    // Randomized stimulus against the model.
    raw = {dsw2, dsw1, dsw0};
    glitch_left = 0; gmask = '0;
    for (int i = 0; i < 4000; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 3) begin
        raw ^= (24'($urandom_range(1, 255)) << (8 * $urandom_range(0, 2)));
      end else if (k == 3 && glitch_left == 0) begin
        glitch_left = int'($urandom_range(1, 10));
        gmask = 24'(1) << $urandom_range(0, 23);
      end
      {dsw2, dsw1, dsw0} = raw ^ ((glitch_left > 0) ? gmask : 24'h0);
      if (glitch_left > 0) glitch_left--;
      evt_ready = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 999) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
